// File: rtl/scoreboard_if.sv
// Decode/issue and writeback signals shared between the pipeline and the register scoreboard.
// Handshake: issue_ready is offered every cycle whether or not dec_valid is high; the decode
// instruction transfers (issue_fire) exactly in a cycle where dec_valid and issue_ready are both 1.
interface scoreboard_if #(
    parameter int NREG = 32
);
    logic            dec_valid;
    logic [31:2]     dec_instr;
    logic            hold;
    logic            flush;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            issue_ready;
    logic            issue_fire;
    logic [NREG-1:0] busy_mask;
    logic            wb_err;

    modport master (
        output dec_valid, dec_instr, hold, flush, wb_valid, wb_rd,
        input  issue_ready, issue_fire, busy_mask, wb_err
    );

    modport slave (
        input  dec_valid, dec_instr, hold, flush, wb_valid, wb_rd,
        output issue_ready, issue_fire, busy_mask, wb_err
    );
endinterface

// File: rtl/scoreboard.sv
// Register scoreboard: per-register pending-write counters gate issue of RV32I instructions.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a retiring write release its last pending source.
module scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    scoreboard_if.slave   sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREG];
    logic             err_q;

    logic [4:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             use_rd;
    logic             rs1_used;
    logic             rs2_used;
    logic             rd_used;
    logic             rs1_fwd;
    logic             rs2_fwd;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rd_sat;
    logic             hazard;
    logic             ready;
    logic             fire;
    logic             spurious_wb;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             unused_bits;

    assign opcode      = sb.dec_instr[6:2];
    assign rd          = sb.dec_instr[11:7];
    assign rs1         = sb.dec_instr[19:15];
    assign rs2         = sb.dec_instr[24:20];
    assign unused_bits = ^{sb.dec_instr[31:25], sb.dec_instr[14:12]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            5'b00000, 5'b11001, 5'b00100: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            5'b01000, 5'b11000: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            5'b01100: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            5'b11011, 5'b00101, 5'b01101: begin
                use_rd  = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
            end
        endcase
    end

    // x0 is hardwired, so a zero register field never participates in hazards.
    assign rs1_used = use_rs1 && (rs1 != 5'd0);
    assign rs2_used = use_rs2 && (rs2 != 5'd0);
    assign rd_used  = use_rd  && (rd  != 5'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign rs1_fwd = sb.wb_valid && (sb.wb_rd == rs1) && (cnt[rs1] == CNT_ONE);
    assign rs2_fwd = sb.wb_valid && (sb.wb_rd == rs2) && (cnt[rs2] == CNT_ONE);
`else
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
`endif

    // Sources use registered counts, so an instruction never waits on its own increment.
    assign rs1_busy = rs1_used && (cnt[rs1] != '0) && !rs1_fwd;
    assign rs2_busy = rs2_used && (cnt[rs2] != '0) && !rs2_fwd;
    assign rd_sat   = rd_used && (cnt[rd] == CNT_MAX);
    assign hazard   = rs1_busy || rs2_busy || rd_sat;
    assign ready    = !hazard && !sb.hold && !sb.flush;
    assign fire     = sb.dec_valid && ready;

    assign spurious_wb = sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt[sb.wb_rd] == '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = fire && rd_used && (rd == 5'(r));
            dec_vec[r] = sb.wb_valid && (sb.wb_rd == 5'(r)) && (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
            if (spurious_wb) begin
                err_q <= 1'b1;
            end
        end
    end

    // Derived from the counter registers, so it trails issue/retire events by one cycle.
    always_comb begin
        sb.busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            sb.busy_mask[r] = (cnt[r] != '0);
        end
    end

    assign sb.issue_ready = ready;
    assign sb.issue_fire  = fire;
    assign sb.wb_err      = err_q;
endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: directed hazard scenarios followed by randomized traffic against a counter model.
// Honours SCOREBOARD_WB_BYPASS_EN for the expected writeback-to-issue latency.
module tb_scoreboard;
    localparam int NREG    = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    scoreboard_if #(.NREG(NREG)) sbif ();

    scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif.slave)
    );

    int checks;
    int errors;
    int mcnt [NREG];
    bit merr;
    logic [NREG-1:0] exp_q [$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic void regs_of(input logic [31:0] ins, output int s1, output int s2, output int d);
        int f1 = int'(ins[19:15]);
        int f2 = int'(ins[24:20]);
        int fd = int'(ins[11:7]);
        s1 = 0;
        s2 = 0;
        d  = 0;
        case (ins[6:2])
            5'b00000, 5'b11001, 5'b00100: begin s1 = f1; d = fd; end
            5'b01000, 5'b11000:           begin s1 = f1; s2 = f2; end
            5'b01100:                     begin s1 = f1; s2 = f2; d = fd; end
            5'b11011, 5'b00101, 5'b01101: begin d = fd; end
            default:                      begin d = 0; end
        endcase
    endfunction

    function automatic bit src_waits(input int s, input bit wv, input int wr);
        int pending;
        if (s == 0) return 1'b0;
        pending = mcnt[s];
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wv && wr == s && pending == 1) pending = 0;
`endif
        return pending > 0;
    endfunction

    function automatic bit model_ready(input logic [31:0] ins, input bit h, input bit f,
                                       input bit wv, input int wr);
        int s1, s2, d;
        regs_of(ins, s1, s2, d);
        if (h || f) return 1'b0;
        if (src_waits(s1, wv, wr) || src_waits(s2, wv, wr)) return 1'b0;
        if (d != 0 && mcnt[d] == CNT_MAX) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(input logic [31:0] ins, input bit fired, input bit wv, input int wr);
        int s1, s2, d;
        int delta [NREG];
        regs_of(ins, s1, s2, d);
        for (int r = 0; r < NREG; r++) delta[r] = 0;
        if (fired && d != 0) delta[d] += 1;
        if (wv && wr != 0) begin
            if (mcnt[wr] > 0) delta[wr] -= 1;
            else merr = 1'b1;
        end
        for (int r = 1; r < NREG; r++) mcnt[r] += delta[r];
    endfunction

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m = '0;
        for (int r = 1; r < NREG; r++) m[r] = (mcnt[r] > 0);
        return m;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) mcnt[r] = 0;
        merr = 1'b0;
    endfunction

    // instruction builders
    function automatic logic [31:0] enc_add(input int d, input int a, input int b);
        return {7'b0, 5'(b), 5'(a), 3'b000, 5'(d), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_addi(input int d, input int a, input int imm);
        return {12'(imm), 5'(a), 3'b000, 5'(d), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lw(input int d, input int a);
        return {12'd0, 5'(a), 3'b010, 5'(d), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int b, input int a);
        return {7'd0, 5'(b), 5'(a), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_lui(input int d, input int imm);
        return {20'(imm), 5'(d), 7'b0110111};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(0, 9);
        int a = $urandom_range(0, 7);
        int b = $urandom_range(0, 7);
        int d = $urandom_range(0, 7);
        logic [31:0] raw;
        case (k)
            0: return enc_add(d, a, b);
            1: return enc_addi(d, a, $urandom_range(0, 4095));
            2: return enc_lw(d, a);
            3: return enc_sw(b, a);
            4: return {7'd0, 5'(b), 5'(a), 3'b000, 5'd0, 7'b1100011};
            5: return {20'd4, 5'(d), 7'b1101111};
            6: return {12'd0, 5'(a), 3'b000, 5'(d), 7'b1100111};
            7: return enc_lui(d, $urandom_range(0, 1000));
            8: return {20'd1, 5'(d), 7'b0010111};
            default: begin
                raw = $urandom();
                raw[1:0] = 2'b11;
                return raw;
            end
        endcase
    endfunction

    // driver: one clock cycle, checks combinational outputs mid-cycle and state after the edge
    task automatic drive_cycle(input bit dv, input logic [31:0] ins, input bit h, input bit f,
                               input bit wv, input int wr, output bit fired);
        bit exp_ready;
        sbif.dec_valid = dv;
        sbif.dec_instr = ins[31:2];
        sbif.hold      = h;
        sbif.flush     = f;
        sbif.wb_valid  = wv;
        sbif.wb_rd     = 5'(wr);
        @(negedge clk);
        exp_ready = model_ready(ins, h, f, wv, wr);
        check("issue_ready", 32'(sbif.issue_ready), 32'(exp_ready));
        check("issue_fire", 32'(sbif.issue_fire), 32'(dv && exp_ready));
        fired = sbif.issue_fire;
        model_step(ins, dv && exp_ready, wv, wr);
        exp_q.push_back(model_mask());
        @(posedge clk);
        #1;
        check("busy_mask", 32'(sbif.busy_mask), 32'(exp_q.pop_front()));
        check("wb_err", 32'(sbif.wb_err), 32'(merr));
    endtask

    task automatic idle_cycle(input bit wv, input int wr);
        bit fired;
        drive_cycle(1'b0, 32'h0000_0013, 1'b0, 1'b0, wv, wr, fired);
    endtask

    initial begin
        bit fired;
        logic [31:0] ins;
        checks = 0;
        errors = 0;
        model_reset();
        rst            = 1'b1;
        sbif.dec_valid = 1'b0;
        sbif.dec_instr = '0;
        sbif.hold      = 1'b0;
        sbif.flush     = 1'b0;
        sbif.wb_valid  = 1'b0;
        sbif.wb_rd     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy_mask", 32'(sbif.busy_mask), 32'h0);
        check("reset_wb_err", 32'(sbif.wb_err), 32'h0);
        rst = 1'b0;

        // reset idle: add x3,x1,x2 issues straight away
        drive_cycle(1'b1, enc_add(3, 1, 2), 1'b0, 1'b0, 1'b0, 0, fired);
        check("idle_fire", 32'(fired), 32'h1);
        check("idle_mask", 32'(sbif.busy_mask), 32'h8);
        idle_cycle(1'b1, 3);

        // RAW hold on x5
        drive_cycle(1'b1, enc_lw(5, 1), 1'b0, 1'b0, 1'b0, 0, fired);
        check("raw_producer", 32'(fired), 32'h1);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, enc_addi(6, 5, 1), 1'b0, 1'b0, 1'b0, 0, fired);
            check("raw_hold", 32'(fired), 32'h0);
        end
        drive_cycle(1'b1, enc_addi(6, 5, 1), 1'b0, 1'b0, 1'b1, 5, fired);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw_wb_cycle", 32'(fired), 32'h1);
`else
        check("raw_wb_cycle", 32'(fired), 32'h0);
        drive_cycle(1'b1, enc_addi(6, 5, 1), 1'b0, 1'b0, 1'b0, 0, fired);
        check("raw_after_wb", 32'(fired), 32'h1);
`endif
        idle_cycle(1'b1, 6);

        // saturation of x7
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, enc_addi(7, 1, i), 1'b0, 1'b0, 1'b0, 0, fired);
            check("sat_fill", 32'(fired), 32'h1);
        end
        drive_cycle(1'b1, enc_addi(7, 1, 9), 1'b0, 1'b0, 1'b0, 0, fired);
        check("sat_block", 32'(fired), 32'h0);
        drive_cycle(1'b1, enc_addi(7, 1, 9), 1'b0, 1'b0, 1'b1, 7, fired);
        check("sat_retire_cycle", 32'(fired), 32'h0);
        drive_cycle(1'b1, enc_addi(7, 1, 9), 1'b0, 1'b0, 1'b0, 0, fired);
        check("sat_after_retire", 32'(fired), 32'h1);
        for (int i = 0; i < 3; i++) idle_cycle(1'b1, 7);
        check("sat_drained", 32'(sbif.busy_mask), 32'h0);

        // simultaneous issue and retire on x4
        drive_cycle(1'b1, enc_lui(4, 1), 1'b0, 1'b0, 1'b0, 0, fired);
        drive_cycle(1'b1, enc_lui(4, 2), 1'b0, 1'b0, 1'b1, 4, fired);
        check("simul_fire", 32'(fired), 32'h1);
        check("simul_mask", 32'(sbif.busy_mask), 32'h10);
        idle_cycle(1'b1, 4);
        check("simul_drained", 32'(sbif.busy_mask), 32'h0);

        // hold and flush block issue but leave counters alone
        drive_cycle(1'b1, enc_lui(8, 1), 1'b1, 1'b0, 1'b0, 0, fired);
        check("hold_block", 32'(fired), 32'h0);
        drive_cycle(1'b1, enc_lui(8, 1), 1'b0, 1'b1, 1'b0, 0, fired);
        check("flush_block", 32'(fired), 32'h0);

        // x0 destinations and register-free opcodes
        drive_cycle(1'b1, enc_addi(0, 0, 1), 1'b0, 1'b0, 1'b0, 0, fired);
        check("x0_fire", 32'(fired), 32'h1);
        drive_cycle(1'b1, 32'h0000_0073, 1'b0, 1'b0, 1'b0, 0, fired);
        check("ecall_fire", 32'(fired), 32'h1);
        drive_cycle(1'b1, 32'h0000_000f, 1'b0, 1'b0, 1'b0, 0, fired);
        check("fence_fire", 32'(fired), 32'h1);
        check("x0_mask", 32'(sbif.busy_mask), 32'h0);
        idle_cycle(1'b1, 0);
        check("wb_x0_err", 32'(sbif.wb_err), 32'h0);

        // spurious retire, then reset with x5 in flight
        idle_cycle(1'b1, 9);
        check("spurious_err", 32'(sbif.wb_err), 32'h1);
        drive_cycle(1'b1, enc_lw(5, 2), 1'b0, 1'b0, 1'b0, 0, fired);
        check("pre_rst_mask", 32'(sbif.busy_mask), 32'h20);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_mask", 32'(sbif.busy_mask), 32'h0);
        check("async_rst_err", 32'(sbif.wb_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int pend [$];
            bit wv;
            int wr;
            for (int r = 1; r < NREG; r++) if (mcnt[r] > 0) pend.push_back(r);
            wv = 1'b0;
            wr = 0;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                wv = 1'b1;
                wr = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 15) == 0) begin
                wv = 1'b1;
                wr = 0;
            end
            ins = rand_instr();
            drive_cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 7) == 0,
                        $urandom_range(0, 7) == 0, wv, wr, fired);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scoreboard.md
# scoreboard

Register scoreboard for the in-order RV32I pipeline, sitting between decode and the issue point. Per-register pending-write counters are incremented when an instruction that writes `rd` issues and decremented when that write retires at writeback. Decode is held while any source register, or a saturated destination counter, has writes still in flight. It replaces stage-by-stage instruction comparison with registered state, so pipeline depth and variable-latency units do not change the hazard logic.

## Interface
- `NREG`, 32: architectural registers tracked; x0 is never tracked.
- `CNT_W`, 2: pending-counter width; each register holds at most 2^CNT_W−1 writes in flight.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dec_valid` in 1: the decode stage holds a valid instruction.
- `dec_instr` in 30 [31:2]: the decode-stage instruction, with bits [1:0] omitted.
- `hold` in 1: downstream stall; blocks issue.
- `flush` in 1: squash the decode instruction this cycle; it does not issue.
- `wb_valid` in 1: a register write retires this cycle.
- `wb_rd` in 5: the register retired by that write.
- `issue_ready` out 1: decode may advance this cycle.
- `issue_fire` out 1: the decode instruction issues this cycle.
- `busy_mask` out NREG: bit r = 1 while counter[r] ≠ 0; bit 0 is always 0.
- `wb_err` out 1: sticky error, a retire arrived for a register with counter = 0.

## Operation
- Register usage is decoded from opcode bits [6:2]:
  - LOAD 00000, JALR 11001, OP_IMM 00100: rs1, rd.
  - STORE 01000, BRANCH 11000: rs1, rs2.
  - OP 01100: rs1, rs2, rd.
  - JAL 11011, AUIPC 00101, LUI 01101: rd only.
  - SYSTEM 11100, MISC_MEM 00011, any other opcode: no registers.
- Any register field equal to 0 is treated as unused.
- A source is busy when it is used and its counter ≠ 0.
- A destination is saturated when it is used and its counter = 2^CNT_W−1.
- `hazard` = busy rs1 | busy rs2 | saturated rd.
- `issue_ready` = ~hazard & ~hold & ~flush.
- `issue_fire` = `dec_valid` & `issue_ready`.
- Per-register counter update, each clock:
  - +1 when `issue_fire` and the instruction writes rd = r.
  - −1 when `wb_valid` and `wb_rd` = r (r ≠ 0) and the counter is nonzero.
  - Both events in the same cycle: the counter is unchanged.
- The counter never wraps:
  - Increment past the maximum is impossible, because a saturated rd blocks issue.
  - A decrement at 0 is dropped and sets `wb_err`.
- `wb_rd` = 0 is ignored entirely and never sets `wb_err`.
- `wb_err` clears only on `rst`.
- Assertion of `flush` or `hold` never modifies counters; only `issue_fire` and writeback do.
- An instruction with rs1 = rs2 = rd, e.g. `add x5,x5,x5`: sources are checked against registered counts before its own increment is applied.

## Timing
- Reset, asynchronous: all counters = 0, `wb_err` = 0, `busy_mask` = 0.
  - With `hold`, `flush` and `dec_instr` sources clear, `issue_ready` = 1 immediately.
- `issue_ready` and `issue_fire` are combinational from the inputs and registered counters; there is no register on this path.
- `busy_mask` is registered; it reflects a counter change one cycle after the issue or retire event.
- Back-to-back dependent pair (producer issued at cycle t, writeback at cycle w):
  - Without the bypass macro, the consumer issues at w+1.
  - With the bypass macro, the consumer issues at w.
- `rst` asserted mid-operation discards all in-flight tracking.
  - Because of this, the pipeline must be flushed together with the scoreboard.

## Configuration
- Macro: `SCOREBOARD_WB_BYPASS_EN`.
- Defined:
  - A source whose counter = 1 and which matches an active `wb_valid`/`wb_rd` this cycle is not busy.
  - Writeback forwards the value to decode in the same cycle.
  - This adds a combinational path from `wb_*` to `issue_ready`.
- Undefined:
  - A source is busy whenever its registered counter ≠ 0.
  - There is no combinational path from `wb_*` to `issue_ready`.

## Test plan
- **Reset idle:** `rst` pulse, `dec_instr` = `add x3,x1,x2`, `dec_valid` = 1 → `issue_ready` = 1, `issue_fire` = 1; one cycle later `busy_mask` = 0x8.
- **RAW hold:** issue `lw x5`, then present `addi x6,x5,1`.
  - Expect `issue_ready` = 0 until `wb_valid`/`wb_rd` = 5.
  - Bypass defined: the consumer issues in the writeback cycle.
  - Bypass undefined: the consumer issues the cycle after writeback.
- **Saturation (CNT_W = 2):** issue three writes to x7 with no writeback.
  - Expect a fourth `addi x7,...` to be blocked.
  - Expect it to issue the cycle after the first retire of x7.
- **Simultaneous events:** with counter[x4] = 1, `issue_fire` for `lui x4` and `wb_rd` = 4 in the same cycle → counter[x4] stays 1 and `busy_mask[4]` stays 1.
- **x0 and no-register opcodes:**
  - `addi x0,x0,1`, `ecall` and `fence` always issue and never set busy bits.
  - `wb_rd` = 0 leaves `wb_err` = 0.
- **Spurious retire and reset mid-flight:**
  - `wb_valid` with `wb_rd` = 9 while counter[x9] = 0 → `wb_err` = 1 next cycle.
  - Then assert `rst` while x5 is busy → `busy_mask` = 0 and `wb_err` = 0 immediately.
